// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator with per-channel divisor, enable and restart.
// Optional one-shot mode is compiled in when TICK_GEN_ONESHOT_EN is defined.
module tick_gen_multi #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CH-1:0]                        en,
  input  logic [N_CH-1:0]                        clr,
  input  logic                                   div_wr,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] div_sel,
  input  logic [DIV_W-1:0]                       div_data,
`ifdef TICK_GEN_ONESHOT_EN
  input  logic [N_CH-1:0]                        oneshot,
`endif
  output logic [N_CH-1:0]                        tick,
  output logic                                   tick_any
);

  logic [DIV_W-1:0] cnt     [N_CH];
  logic [DIV_W-1:0] div     [N_CH];
  logic [DIV_W-1:0] cnt_nxt [N_CH];
  logic [DIV_W-1:0] div_nxt [N_CH];
  logic [N_CH-1:0]  tick_nxt;
`ifdef TICK_GEN_ONESHOT_EN
  logic [N_CH-1:0]  armed;
  logic [N_CH-1:0]  armed_nxt;
`endif

  always_comb begin
    tick_nxt = '0;
`ifdef TICK_GEN_ONESHOT_EN
    armed_nxt = armed;
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = cnt[i];
      div_nxt[i] = div[i];
      // div_sel values at or beyond N_CH never match any channel index
      if (div_wr && (32'(div_sel) == i))
        div_nxt[i] = div_data;
      if (clr[i] || (div_wr && (32'(div_sel) == i))) begin
        cnt_nxt[i] = '0;
`ifdef TICK_GEN_ONESHOT_EN
        armed_nxt[i] = 1'b1;
`endif
      end else if (en[i]) begin
`ifdef TICK_GEN_ONESHOT_EN
        if (oneshot[i] && !armed[i]) begin
          cnt_nxt[i] = '0;
        end else
`endif
        // >= compare makes any out-of-range count wrap; div of 0 or 1 ticks every cycle
        if ((div[i] <= DIV_W'(1)) || (cnt[i] >= div[i] - DIV_W'(1))) begin
          cnt_nxt[i]  = '0;
          tick_nxt[i] = 1'b1;
`ifdef TICK_GEN_ONESHOT_EN
          if (oneshot[i])
            armed_nxt[i] = 1'b0;
`endif
        end else begin
          cnt_nxt[i] = cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '{default: '0};
      div      <= '{default: DIV_W'(DEFAULT_DIV)};
      tick     <= '0;
      tick_any <= 1'b0;
`ifdef TICK_GEN_ONESHOT_EN
      armed    <= '1;
`endif
    end else begin
      cnt      <= cnt_nxt;
      div      <= div_nxt;
      tick     <= tick_nxt;
      tick_any <= |tick_nxt;
`ifdef TICK_GEN_ONESHOT_EN
      armed    <= armed_nxt;
`endif
    end
  end

endmodule
